// File: rtl/l2_dir_ctrl.sv
// l2_dir_ctrl: blocking L2 directory controller for a two-core MESI model.
// Takes arbitrated core requests on msg1 and core/memory responses on msg3.
// Drives invalidations, memory loads/stores and grants on msg2. Each msg2
// message is a one-cycle registered pulse. The directory keeps per-tag
// state only; there is no L2 data array.
//
// Ports
//   clk, rst                         clock, async active-high reset
//   msg1_type/data/tag/source        request in (data ignored)
//   msg3_type/data/tag/source        response in (INV_FWD_ACK / LOAD_MEM_ACK)
//   msg2_type/data/tag/load_tag      message out
//   mesi_send, cache_owner           granted state and destination of DATA_ACK
//   share_list                       INV_FWD target mask
//   err_timeout                      sticky, set when a WAIT state expires
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | ready for a new request
// LOOKUP   | read the dir entry, pick the cores that must be invalidated
// SEND_INV | INV_FWD on msg2
// WAIT_INV | collect INV_FWD_ACKs from the targeted cores
// SEND_WB  | STORE_MEM on msg2 (dirty data returned by the EM owner)
// SEND_MEM | LOAD_MEM on msg2
// WAIT_MEM | wait for LOAD_MEM_ACK
// SEND_ACK | DATA_ACK on msg2, dir entry updated on exit

`timescale 1ns/1ps

module l2_dir_ctrl #(
    parameter int ACK_TIMEOUT = 15,
    parameter int MSG_WIDTH   = 4,
    parameter int DATA_WIDTH  = 8,
    parameter int TAG_WIDTH   = 4,
    parameter int OWNER_BITS  = 1,
    parameter int MESI_WIDTH  = 2,
    parameter int DIR_WIDTH   = 2,
    parameter int TAG_ARRAY   = 1 << TAG_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MSG_WIDTH-1:0]  msg1_type,
    input  logic [DATA_WIDTH-1:0] msg1_data,
    input  logic [TAG_WIDTH-1:0]  msg1_tag,
    input  logic [OWNER_BITS-1:0] msg1_source,
    input  logic [MSG_WIDTH-1:0]  msg3_type,
    input  logic [DATA_WIDTH-1:0] msg3_data,
    input  logic [TAG_WIDTH-1:0]  msg3_tag,
    input  logic [OWNER_BITS-1:0] msg3_source,
    output logic [MSG_WIDTH-1:0]  msg2_type,
    output logic [DATA_WIDTH-1:0] msg2_data,
    output logic [TAG_WIDTH-1:0]  msg2_tag,
    output logic [TAG_WIDTH-1:0]  msg2_load_tag,
    output logic [MESI_WIDTH-1:0] mesi_send,
    output logic [OWNER_BITS-1:0] cache_owner,
    output logic [DIR_WIDTH-1:0]  share_list,
    output logic                  err_timeout
);

    localparam logic [MSG_WIDTH-1:0] MSG_EMPTY        = MSG_WIDTH'(0);
    localparam logic [MSG_WIDTH-1:0] MSG_LOAD_REQ     = MSG_WIDTH'(1);
    localparam logic [MSG_WIDTH-1:0] MSG_STORE_REQ    = MSG_WIDTH'(2);
    localparam logic [MSG_WIDTH-1:0] MSG_INV_FWD      = MSG_WIDTH'(3);
    localparam logic [MSG_WIDTH-1:0] MSG_INV_FWD_ACK  = MSG_WIDTH'(4);
    localparam logic [MSG_WIDTH-1:0] MSG_LOAD_MEM     = MSG_WIDTH'(5);
    localparam logic [MSG_WIDTH-1:0] MSG_STORE_MEM    = MSG_WIDTH'(6);
    localparam logic [MSG_WIDTH-1:0] MSG_LOAD_MEM_ACK = MSG_WIDTH'(7);
    localparam logic [MSG_WIDTH-1:0] MSG_DATA_ACK     = MSG_WIDTH'(8);

    localparam logic [MESI_WIDTH-1:0] MESI_S = MESI_WIDTH'(1);
    localparam logic [MESI_WIDTH-1:0] MESI_E = MESI_WIDTH'(2);
    localparam logic [MESI_WIDTH-1:0] MESI_M = MESI_WIDTH'(3);

    localparam logic [1:0] ST_I  = 2'd0;
    localparam logic [1:0] ST_S  = 2'd1;
    localparam logic [1:0] ST_EM = 2'd2;

    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_SEND_INV, S_WAIT_INV,
        S_SEND_WB, S_SEND_MEM, S_WAIT_MEM, S_SEND_ACK
    } state_t;

    state_t state, state_d;

    logic [1:0]            dir_st  [TAG_ARRAY];
    logic [DIR_WIDTH-1:0]  dir_sh  [TAG_ARRAY];
    logic [OWNER_BITS-1:0] dir_own [TAG_ARRAY];

    logic                  req_store;
    logic [TAG_WIDTH-1:0]  req_tag;
    logic [OWNER_BITS-1:0] req_src;
    logic [DIR_WIDTH-1:0]  pending;
    logic                  got_data;
    logic [DATA_WIDTH-1:0] data_q;
    logic [TW-1:0]         timer;

    logic [1:0]            cur_st;
    logic [DIR_WIDTH-1:0]  cur_sh;
    logic [OWNER_BITS-1:0] cur_own;
    logic [DIR_WIDTH-1:0]  req_oh, own_oh, src3_oh, holders, tgt;
    logic                  req_valid, inv_ack, inv_done, owner_ack, mem_ack;
    logic [MESI_WIDTH-1:0] grant_mesi;
    logic                  timeout_hit;

    logic [MSG_WIDTH-1:0]  msg2_type_d;
    logic [DATA_WIDTH-1:0] msg2_data_d;
    logic [TAG_WIDTH-1:0]  msg2_tag_d, msg2_load_tag_d;
    logic [MESI_WIDTH-1:0] mesi_send_d;
    logic [OWNER_BITS-1:0] cache_owner_d;
    logic [DIR_WIDTH-1:0]  share_list_d;

    logic unused_msg1;
    assign unused_msg1 = ^msg1_data;

    // The dir entry of the in-flight tag cannot change until SEND_ACK, so it
    // is read live rather than copied at LOOKUP.
    always_comb begin
        cur_st    = dir_st[req_tag];
        cur_sh    = dir_sh[req_tag];
        cur_own   = dir_own[req_tag];
        req_oh    = DIR_WIDTH'(1) << req_src;
        own_oh    = DIR_WIDTH'(1) << cur_own;
        src3_oh   = DIR_WIDTH'(1) << msg3_source;
        req_valid = (msg1_type == MSG_LOAD_REQ) || (msg1_type == MSG_STORE_REQ);

        holders = '0;
        if (cur_st == ST_EM)
            holders = own_oh;
        else if (cur_st == ST_S)
            holders = cur_sh;
        tgt = holders & ~req_oh;

        inv_ack   = (state == S_WAIT_INV) && (msg3_type == MSG_INV_FWD_ACK) &&
                    (msg3_tag == req_tag) && ((pending & src3_oh) != '0);
        inv_done  = inv_ack && ((pending & ~src3_oh) == '0);
        owner_ack = inv_ack && (cur_st == ST_EM) && (msg3_source == cur_own);
        mem_ack   = (state == S_WAIT_MEM) && (msg3_type == MSG_LOAD_MEM_ACK) &&
                    (msg3_tag == req_tag);

        if (req_store)
            grant_mesi = MESI_M;
        else if (cur_st == ST_S)
            grant_mesi = MESI_S;
        else
            grant_mesi = MESI_E;
    end

    // Next state and next msg2 contents; msg2 is loaded on the edge that
    // enters the matching SEND_* state, so the message is visible there.
    always_comb begin
        state_d         = state;
        timeout_hit     = 1'b0;
        msg2_type_d     = MSG_EMPTY;
        msg2_data_d     = '0;
        msg2_tag_d      = '0;
        msg2_load_tag_d = '0;
        mesi_send_d     = '0;
        cache_owner_d   = '0;
        share_list_d    = '0;

        unique case (state)
            S_IDLE: begin
                if (req_valid)
                    state_d = S_LOOKUP;
            end
            S_LOOKUP: begin
                if ((tgt != '0) && (req_store || (cur_st == ST_EM))) begin
                    state_d      = S_SEND_INV;
                    msg2_type_d  = MSG_INV_FWD;
                    msg2_tag_d   = req_tag;
                    share_list_d = tgt;
                end else begin
                    state_d         = S_SEND_MEM;
                    msg2_type_d     = MSG_LOAD_MEM;
                    msg2_load_tag_d = req_tag;
                end
            end
            S_SEND_INV: state_d = S_WAIT_INV;
            S_WAIT_INV: begin
                if (inv_done) begin
                    if (got_data || owner_ack) begin
                        state_d         = S_SEND_WB;
                        msg2_type_d     = MSG_STORE_MEM;
                        msg2_tag_d      = req_tag;
                        msg2_load_tag_d = req_tag;
                        msg2_data_d     = owner_ack ? msg3_data : data_q;
                    end else begin
                        state_d         = S_SEND_MEM;
                        msg2_type_d     = MSG_LOAD_MEM;
                        msg2_load_tag_d = req_tag;
                    end
                end else if (timer == TW'(1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_SEND_WB: begin
                state_d       = S_SEND_ACK;
                msg2_type_d   = MSG_DATA_ACK;
                msg2_data_d   = data_q;
                msg2_tag_d    = req_tag;
                mesi_send_d   = grant_mesi;
                cache_owner_d = req_src;
            end
            S_SEND_MEM: state_d = S_WAIT_MEM;
            S_WAIT_MEM: begin
                if (mem_ack) begin
                    state_d       = S_SEND_ACK;
                    msg2_type_d   = MSG_DATA_ACK;
                    msg2_data_d   = msg3_data;
                    msg2_tag_d    = req_tag;
                    mesi_send_d   = grant_mesi;
                    cache_owner_d = req_src;
                end else if (timer == TW'(1)) begin
                    timeout_hit = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            S_SEND_ACK: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            req_store     <= 1'b0;
            req_tag       <= '0;
            req_src       <= '0;
            pending       <= '0;
            got_data      <= 1'b0;
            data_q        <= '0;
            timer         <= '0;
            err_timeout   <= 1'b0;
            msg2_type     <= MSG_EMPTY;
            msg2_data     <= '0;
            msg2_tag      <= '0;
            msg2_load_tag <= '0;
            mesi_send     <= '0;
            cache_owner   <= '0;
            share_list    <= '0;
            for (int i = 0; i < TAG_ARRAY; i++) begin
                dir_st[i]  <= ST_I;
                dir_sh[i]  <= '0;
                dir_own[i] <= '0;
            end
        end else begin
            state         <= state_d;
            msg2_type     <= msg2_type_d;
            msg2_data     <= msg2_data_d;
            msg2_tag      <= msg2_tag_d;
            msg2_load_tag <= msg2_load_tag_d;
            mesi_send     <= mesi_send_d;
            cache_owner   <= cache_owner_d;
            share_list    <= share_list_d;

            if ((state == S_IDLE) && req_valid) begin
                req_store <= (msg1_type == MSG_STORE_REQ);
                req_tag   <= msg1_tag;
                req_src   <= msg1_source;
            end

            if (state == S_LOOKUP) begin
                pending  <= tgt;
                got_data <= 1'b0;
            end

            if (inv_ack)
                pending <= pending & ~src3_oh;
            if (owner_ack) begin
                data_q   <= msg3_data;
                got_data <= 1'b1;
            end
            if (mem_ack)
                data_q <= msg3_data;

            // Down-counter armed on the way into either WAIT state.
            if ((state == S_SEND_INV) || (state == S_SEND_MEM))
                timer <= TW'(ACK_TIMEOUT);
            else if (((state == S_WAIT_INV) || (state == S_WAIT_MEM)) && (timer != '0))
                timer <= timer - TW'(1);

            if (timeout_hit)
                err_timeout <= 1'b1;

            if (state == S_SEND_ACK) begin
                if (!req_store && (cur_st == ST_S)) begin
                    dir_sh[req_tag] <= cur_sh | req_oh;
                end else begin
                    dir_st[req_tag]  <= ST_EM;
                    dir_own[req_tag] <= req_src;
                    dir_sh[req_tag]  <= req_oh;
                end
            end
        end
    end

endmodule

// File: tb/tb_l2_dir_ctrl.sv
`timescale 1ns/1ps

module tb_l2_dir_ctrl;

    localparam int ACK_TIMEOUT = 15;

    localparam logic [3:0] EMPTY        = 4'd0;
    localparam logic [3:0] LOAD_REQ     = 4'd1;
    localparam logic [3:0] STORE_REQ    = 4'd2;
    localparam logic [3:0] INV_FWD      = 4'd3;
    localparam logic [3:0] INV_FWD_ACK  = 4'd4;
    localparam logic [3:0] LOAD_MEM     = 4'd5;
    localparam logic [3:0] STORE_MEM    = 4'd6;
    localparam logic [3:0] LOAD_MEM_ACK = 4'd7;
    localparam logic [3:0] DATA_ACK     = 4'd8;

    localparam logic [1:0] MESI_S = 2'd1;
    localparam logic [1:0] MESI_E = 2'd2;
    localparam logic [1:0] MESI_M = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] msg1_type = EMPTY;
    logic [7:0] msg1_data = '0;
    logic [3:0] msg1_tag = '0;
    logic       msg1_source = 1'b0;
    logic [3:0] msg3_type = EMPTY;
    logic [7:0] msg3_data = '0;
    logic [3:0] msg3_tag = '0;
    logic       msg3_source = 1'b0;
    logic [3:0] msg2_type;
    logic [7:0] msg2_data;
    logic [3:0] msg2_tag;
    logic [3:0] msg2_load_tag;
    logic [1:0] mesi_send;
    logic       cache_owner;
    logic [1:0] share_list;
    logic       err_timeout;

    l2_dir_ctrl #(.ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .msg1_type(msg1_type), .msg1_data(msg1_data), .msg1_tag(msg1_tag), .msg1_source(msg1_source),
        .msg3_type(msg3_type), .msg3_data(msg3_data), .msg3_tag(msg3_tag), .msg3_source(msg3_source),
        .msg2_type(msg2_type), .msg2_data(msg2_data), .msg2_tag(msg2_tag), .msg2_load_tag(msg2_load_tag),
        .mesi_send(mesi_send), .cache_owner(cache_owner), .share_list(share_list),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference directory: who holds each line, in I / S / EM terms.
    typedef enum int {M_I, M_S, M_EM} mst_t;
    mst_t       m_st  [16];
    logic [1:0] m_sh  [16];
    logic       m_own [16];
    logic       m_err;

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_st[i]  = M_I;
            m_sh[i]  = 2'b00;
            m_own[i] = 1'b0;
        end
        m_err = 1'b0;
    endtask

    task automatic clear_in();
        msg1_type = EMPTY;
        msg3_type = EMPTY;
    endtask

    // Traffic that a busy controller must ignore: requests, wrong-tag
    // responses, and acks from a core that was never asked to invalidate.
    task automatic drive_noise(input logic [3:0] tag, input logic src);
        logic [3:0] wtag;
        wtag = tag ^ 4'($urandom_range(1, 15));
        case ($urandom_range(0, 3))
            0: begin
                msg1_type   = ($urandom_range(0, 1) == 0) ? LOAD_REQ : STORE_REQ;
                msg1_tag    = 4'($urandom);
                msg1_source = 1'($urandom);
            end
            1: begin
                msg3_type = LOAD_MEM_ACK; msg3_tag = wtag; msg3_data = 8'($urandom);
            end
            2: begin
                msg3_type = INV_FWD_ACK; msg3_tag = wtag; msg3_source = 1'($urandom);
                msg3_data = 8'($urandom);
            end
            default: begin
                msg3_type = INV_FWD_ACK; msg3_tag = tag; msg3_source = src;
                msg3_data = 8'($urandom);
            end
        endcase
    endtask

    task automatic wait_msg(input int budget, input bit noise, input logic [3:0] tag,
                            input logic src, output int lat);
        lat = 0;
        while (lat < budget) begin
            @(negedge clk);
            lat++;
            clear_in();
            if (msg2_type != EMPTY) break;
            if (noise && ($urandom_range(0, 1) == 0)) drive_noise(tag, src);
        end
    endtask

    task automatic gap(input int dly, input bit noise, input logic [3:0] tag, input logic src);
        if (noise) drive_noise(tag, src);
        repeat (dly) begin
            @(negedge clk);
            clear_in();
            if (noise && ($urandom_range(0, 1) == 0)) drive_noise(tag, src);
        end
        @(negedge clk);
        clear_in();
    endtask

    // mode 0: normal, 1: withhold the response (timeout), 2: reset mid-transaction
    task automatic do_txn(input bit is_store, input logic [3:0] tag, input logic src,
                          input int mode, input int dly, input bit noise, input logic [7:0] dval);
        logic [1:0] holders, tgt;
        logic       inv, wb;
        logic [1:0] exp_mesi;
        logic [7:0] ack_data;
        int         lat, loud;

        case (m_st[tag])
            M_EM:    holders = 2'b01 << m_own[tag];
            M_S:     holders = m_sh[tag];
            default: holders = 2'b00;
        endcase
        tgt = holders & ~(2'b01 << src);
        inv = (tgt != 2'b00) && (is_store || (m_st[tag] == M_EM));
        wb  = inv && (m_st[tag] == M_EM);
        if (is_store)             exp_mesi = MESI_M;
        else if (m_st[tag] == M_S) exp_mesi = MESI_S;
        else                      exp_mesi = MESI_E;
        ack_data = wb ? dval : 8'($urandom);

        @(negedge clk);
        msg1_type   = is_store ? STORE_REQ : LOAD_REQ;
        msg1_tag    = tag;
        msg1_source = src;
        msg1_data   = 8'($urandom);

        wait_msg(8, noise, tag, src, lat);
        chk("req_latency", lat, 2);
        chk("first_type", msg2_type, inv ? INV_FWD : LOAD_MEM);
        if (inv) chk("inv_mask", share_list, tgt);
        else     chk("load_tag", msg2_load_tag, tag);

        if (mode == 2) begin
            rst = 1'b1;
            #1;
            chk("rst_msg2_empty", msg2_type, EMPTY);
            chk("rst_err_clear", err_timeout, 0);
            @(negedge clk);
            rst = 1'b0;
            model_reset();
            return;
        end

        if (mode == 1) begin
            loud = 0;
            for (int i = 1; i <= ACK_TIMEOUT + 1; i++) begin
                @(negedge clk);
                if (msg2_type != EMPTY) loud++;
                if (i == ACK_TIMEOUT) chk("tmo_not_early", err_timeout, m_err);
            end
            m_err = 1'b1;
            chk("tmo_err", err_timeout, 1);
            chk("tmo_quiet", loud, 0);
            return;
        end

        if (inv) begin
            gap(dly, noise, tag, src);
            for (int c = 0; c < 2; c++) begin
                if (tgt[c]) begin
                    if (c != 0 && tgt[0]) begin @(negedge clk); clear_in(); end
                    msg3_type = INV_FWD_ACK; msg3_tag = tag; msg3_source = 1'(c);
                    msg3_data = ack_data;
                end
            end
            wait_msg(6, 1'b0, tag, src, lat);
            chk("inv_ack_latency", lat, 1);
            if (wb) begin
                chk("wb_type", msg2_type, STORE_MEM);
                chk("wb_tag", msg2_tag, tag);
                chk("wb_load_tag", msg2_load_tag, tag);
                chk("wb_data", msg2_data, dval);
                // stale read produced by the write-back must be discarded
                msg3_type = LOAD_MEM_ACK; msg3_tag = tag; msg3_data = ~dval;
                wait_msg(4, 1'b0, tag, src, lat);
                chk("wb_ack_latency", lat, 1);
            end else begin
                chk("post_inv_type", msg2_type, LOAD_MEM);
                chk("post_inv_load_tag", msg2_load_tag, tag);
            end
        end

        if (!wb) begin
            gap(dly, noise, tag, src);
            msg3_type = LOAD_MEM_ACK; msg3_tag = tag; msg3_data = dval;
            wait_msg(4, 1'b0, tag, src, lat);
            chk("mem_ack_latency", lat, 1);
        end

        chk("ack_type", msg2_type, DATA_ACK);
        chk("ack_owner", cache_owner, src);
        chk("ack_tag", msg2_tag, tag);
        chk("ack_data", msg2_data, dval);
        chk("ack_mesi", mesi_send, exp_mesi);

        if (is_store || m_st[tag] != M_S) begin
            m_st[tag]  = M_EM;
            m_own[tag] = src;
            m_sh[tag]  = 2'b01 << src;
        end else begin
            m_sh[tag] = m_sh[tag] | (2'b01 << src);
        end

        // a late stale read arriving in IDLE must also be ignored
        if (wb) begin msg3_type = LOAD_MEM_ACK; msg3_tag = tag; msg3_data = 8'($urandom); end
        @(negedge clk);
        clear_in();
        chk("ack_pulse", msg2_type, EMPTY);
        chk("err_sticky", err_timeout, m_err);
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_type", msg2_type, EMPTY);
        chk("rst_data", msg2_data, 0);
        chk("rst_share", share_list, 0);
        chk("rst_owner", cache_owner, 0);
        chk("rst_mesi", mesi_send, 0);
        chk("rst_err", err_timeout, 0);
        rst = 1'b0;

        do_txn(1'b0, 4'd5, 1'b0, 0, 0, 1'b0, 8'hAB);
        do_txn(1'b0, 4'd5, 1'b1, 0, 0, 1'b0, 8'hCD);
        do_txn(1'b1, 4'd5, 1'b0, 0, 1, 1'b0, 8'h5A);
        do_txn(1'b0, 4'd3, 1'b0, 0, 3, 1'b1, 8'h11);
        do_txn(1'b0, 4'd3, 1'b1, 1, 0, 1'b0, 8'h22);
        do_txn(1'b0, 4'd3, 1'b1, 0, 2, 1'b0, 8'h33);
        do_txn(1'b1, 4'd3, 1'b0, 2, 0, 1'b0, 8'h44);
        do_txn(1'b0, 4'd3, 1'b0, 0, 0, 1'b0, 8'h55);

        for (int n = 0; n < 150; n++) begin
            int r, mode;
            r    = $urandom_range(0, 29);
            mode = (r == 0) ? 1 : ((r == 1) ? 2 : 0);
            do_txn(1'($urandom), 4'($urandom_range(0, 3)), 1'($urandom), mode,
                   $urandom_range(0, 3), (mode == 0) && ($urandom_range(0, 1) == 1),
                   8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
